// File: rtl/sa_edge_feeder.sv
// sa_edge_feeder
//   Edge sequencer for an N x N output-stationary systolic MAC array.
//   A host loads operand matrices A and B (both row-major) while the block
//   is idle. A start pulse then streams A rows into the west edge and
//   B columns into the north edge with a one-cycle diagonal skew per lane.
//   The run lasts 3N-2 slices, so the last operand reaches cell (N-1,N-1).
//   A one-cycle done pulse follows the run.
//
// Ports
//   clk, rst_n     : clock and asynchronous active-low reset
//   wr_en/wr_sel   : operand write strobe and matrix select (0 = A, 1 = B)
//   wr_addr/wr_data: element index (row*N + col) and operand value
//   start          : begin a run; only sampled while idle
//   busy           : high during FEED and DONE
//   feed_valid     : high while the lanes carry a run slice
//   done           : one-cycle pulse at the end of a run
//   a_out / b_out  : west (row i) and north (column j) lanes, lane k = bits [W*k +: W]
module sa_edge_feeder #(
    parameter int             N   = 4,
    parameter int             W   = 8,
    parameter logic [W-1:0]   PAD = 8'h00
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic                   wr_sel,
    input  logic [2*$clog2(N)-1:0] wr_addr,
    input  logic [W-1:0]           wr_data,
    input  logic                   start,
    output logic                   busy,
    output logic                   feed_valid,
    output logic                   done,
    output logic [N*W-1:0]         a_out,
    output logic [N*W-1:0]         b_out
);

    localparam int AW = 2 * $clog2(N);
    localparam int CW = $clog2(3 * N - 2);
    localparam logic [CW-1:0] LAST = CW'(3 * N - 3);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FEED = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N*W-1:0]  a_out_q, a_out_d;
    logic [N*W-1:0]  b_out_q, b_out_d;
    logic            busy_q, busy_d;
    logic            feed_valid_q, feed_valid_d;
    logic            done_q, done_d;

    logic [W-1:0]    mem_a_q [N*N];
    logic [W-1:0]    mem_a_d [N*N];
    logic [W-1:0]    mem_b_q [N*N];
    logic [W-1:0]    mem_b_d [N*N];

    // Index of the slice to be loaded into the lane registers this edge.
    logic [CW-1:0]   slice_t;
    logic            slice_load;
    logic [N*W-1:0]  slice_a;
    logic [N*W-1:0]  slice_b;
    logic            wr_ok;

    // Writes land only while idle, and never on the edge that accepts start,
    // so a run always sees storage exactly as it was before it began.
    assign wr_ok = wr_en && (state_q == ST_IDLE) && !start;

    always_comb begin
        mem_a_d = mem_a_q;
        mem_b_d = mem_b_q;
        if (wr_ok) begin
            if (wr_sel) begin
                mem_b_d[wr_addr] = wr_data;
            end else begin
                mem_a_d[wr_addr] = wr_data;
            end
        end
    end

    // Skewed slice: lane gi carries element (t - gi) of its row/column,
    // or PAD when that offset falls outside 0..N-1.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            localparam logic [CW-1:0] LO = CW'(gi);
            localparam logic [CW-1:0] HI = CW'(gi + N);
            logic          in_range;
            logic [AW-1:0] k_off;
            logic [AW-1:0] a_idx;
            logic [AW-1:0] b_idx;

            assign in_range = (slice_t >= LO) && (slice_t < HI);
            assign k_off    = AW'(slice_t - LO);
            assign a_idx    = AW'(gi * N) + k_off;          // A[gi][t-gi]
            assign b_idx    = AW'(k_off * AW'(N)) + AW'(gi); // B[t-gi][gi]
            assign slice_a[gi*W +: W] = in_range ? mem_a_q[a_idx] : PAD;
            assign slice_b[gi*W +: W] = in_range ? mem_b_q[b_idx] : PAD;
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        busy_d       = 1'b0;
        feed_valid_d = 1'b0;
        done_d       = 1'b0;
        slice_t      = '0;
        slice_load   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_FEED;
                    cnt_d        = '0;
                    slice_load   = 1'b1;
                    busy_d       = 1'b1;
                    feed_valid_d = 1'b1;
                end
            end
            ST_FEED: begin
                busy_d = 1'b1;
                if (cnt_q < LAST) begin
                    cnt_d        = cnt_q + 1'b1;
                    slice_t      = cnt_q + 1'b1;
                    slice_load   = 1'b1;
                    feed_valid_d = 1'b1;
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        a_out_d = slice_load ? slice_a : {N{PAD}};
        b_out_d = slice_load ? slice_b : {N{PAD}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            a_out_q      <= {N{PAD}};
            b_out_q      <= {N{PAD}};
            busy_q       <= 1'b0;
            feed_valid_q <= 1'b0;
            done_q       <= 1'b0;
            for (int k = 0; k < N * N; k++) begin
                mem_a_q[k] <= PAD;
                mem_b_q[k] <= PAD;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_out_q      <= a_out_d;
            b_out_q      <= b_out_d;
            busy_q       <= busy_d;
            feed_valid_q <= feed_valid_d;
            done_q       <= done_d;
            mem_a_q      <= mem_a_d;
            mem_b_q      <= mem_b_d;
        end
    end

    assign busy       = busy_q;
    assign feed_valid = feed_valid_q;
    assign done       = done_q;
    assign a_out      = a_out_q;
    assign b_out      = b_out_q;

endmodule

// File: tb/tb_sa_edge_feeder.sv
// Testbench for sa_edge_feeder: directed plus randomized operand loads,
// every run compared cycle by cycle against a matrix-level reference model.
module tb_sa_edge_feeder;

    localparam int N = 4;
    localparam int W = 8;
    localparam int T = 3 * N - 2;

    logic           clk;
    logic           rst_n;
    logic           wr_en;
    logic           wr_sel;
    logic [3:0]     wr_addr;
    logic [W-1:0]   wr_data;
    logic           start;
    logic           busy;
    logic           feed_valid;
    logic           done;
    logic [N*W-1:0] a_out;
    logic [N*W-1:0] b_out;

    int n_tests;
    int n_fail;

    // Reference storage: plain matrices.
    logic [W-1:0] ref_a [N][N];
    logic [W-1:0] ref_b [N][N];

    // Observed lanes of the most recent run, indexed by slice number.
    logic [N*W-1:0] obs_a [T];
    logic [N*W-1:0] obs_b [T];

    sa_edge_feeder #(.N(N), .W(W), .PAD(8'h00)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .busy       (busy),
        .feed_valid (feed_valid),
        .done       (done),
        .a_out      (a_out),
        .b_out      (b_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Row i of the west edge sees A[i][t-i]; column j of the north edge sees B[t-j][j].
    function automatic logic [N*W-1:0] exp_a(input int t);
        logic [N*W-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (t - i >= 0 && t - i < N) v[i*W +: W] = ref_a[i][t-i];
        end
        return v;
    endfunction

    function automatic logic [N*W-1:0] exp_b(input int t);
        logic [N*W-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++) begin
            if (t - j >= 0 && t - j < N) v[j*W +: W] = ref_b[t-j][j];
        end
        return v;
    endfunction

    task automatic write_op(input logic sel, input int row, input int col, input logic [W-1:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = 4'(row * N + col);
        wr_data = data;
        tick();
        wr_en   = 1'b0;
        if (sel) ref_b[row][col] = data;
        else     ref_a[row][col] = data;
        $display("[TB] write %s[%0d][%0d] = %h", sel ? "B" : "A", row, col, data);
    endtask

    // One full run starting from IDLE. hold keeps start high afterwards;
    // inj_t >= 0 pulses a write of A[0][0]=0x7F plus start during FEED.
    // collide writes A[0][0]=0x11 on the same edge as the accepted start.
    task automatic do_run(input string tag, input bit hold, input int inj_t, input bit collide);
        start = 1'b1;
        if (collide) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'h11;
        end
        tick();
        wr_en = 1'b0;
        if (!hold) start = 1'b0;
        for (int t = 0; t < T; t++) begin
            obs_a[t] = a_out;
            obs_b[t] = b_out;
            check_val({tag, ".a"},     64'(a_out),      64'(exp_a(t)));
            check_val({tag, ".b"},     64'(b_out),      64'(exp_b(t)));
            check_val({tag, ".valid"}, 64'(feed_valid), 64'd1);
            check_val({tag, ".busy"},  64'(busy),       64'd1);
            check_val({tag, ".done"},  64'(done),       64'd0);
            if (t == inj_t) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'h7F;
                start = 1'b1;
            end
            if (t < T - 1) tick();
            if (t == inj_t) begin
                wr_en = 1'b0;
                if (!hold) start = 1'b0;
            end
        end
        tick();
        check_val({tag, ".done_pulse"}, 64'(done),       64'd1);
        check_val({tag, ".done_valid"}, 64'(feed_valid), 64'd0);
        check_val({tag, ".done_busy"},  64'(busy),       64'd1);
        check_val({tag, ".done_a"},     64'(a_out),      64'd0);
        check_val({tag, ".done_b"},     64'(b_out),      64'd0);
        tick();
        check_val({tag, ".idle_busy"},  64'(busy),       64'd0);
        check_val({tag, ".idle_done"},  64'(done),       64'd0);
        $display("[TB] run %s complete", tag);
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ref_a[i][j] = 8'h00;
                ref_b[i][j] = 8'h00;
            end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b1;
        wr_en   = 1'b0;
        wr_sel  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;
        clear_model();

        // Asynchronous reset mid-cycle.
        #3 rst_n = 1'b0;
        #1;
        check_val("rst.a",     64'(a_out),      64'd0);
        check_val("rst.b",     64'(b_out),      64'd0);
        check_val("rst.busy",  64'(busy),       64'd0);
        check_val("rst.valid", 64'(feed_valid), 64'd0);
        check_val("rst.done",  64'(done),       64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_val("idle.a",    64'(a_out), 64'd0);
            check_val("idle.b",    64'(b_out), 64'd0);
            check_val("idle.busy", 64'(busy),  64'd0);
        end
        $display("[TB] reset/idle checks done");

        // Directed pattern.
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                write_op(1'b0, i, k, 8'(8'h30 + 4 * i + k));
                write_op(1'b1, i, k, 8'(8'h50 + 4 * i + k));
            end
        do_run("directed", 1'b0, -1, 1'b0);
        check_val("dir.a0", 64'(obs_a[0]), 64'h00000030);
        check_val("dir.b0", 64'(obs_b[0]), 64'h00000050);
        check_val("dir.a3", 64'(obs_a[3]), 64'h3C393633);
        check_val("dir.b3", 64'(obs_b[3]), 64'h5356595C);
        check_val("dir.a6", 64'(obs_a[6]), 64'h3F000000);
        check_val("dir.b6", 64'(obs_b[6]), 64'h5F000000);
        for (int t = 7; t < T; t++) begin
            check_val("dir.pad_a", 64'(obs_a[t]), 64'd0);
            check_val("dir.pad_b", 64'(obs_b[t]), 64'd0);
        end

        // Write and start during FEED are ignored; model unchanged.
        do_run("ignored", 1'b0, 2, 1'b0);
        tick();
        check_val("ignored.no_rerun", 64'(busy), 64'd0);
        do_run("after_ignored", 1'b0, -1, 1'b0);
        check_val("after_ignored.a00", 64'(obs_a[0]), 64'h00000030);

        // Write coincident with accepted start is dropped.
        do_run("collide", 1'b0, -1, 1'b1);
        check_val("collide.a00", 64'(obs_a[0]), 64'h00000030);
        do_run("after_collide", 1'b0, -1, 1'b0);

        // Back-to-back: start held high across two runs.
        do_run("b2b_1", 1'b1, -1, 1'b0);
        do_run("b2b_2", 1'b0, -1, 1'b0);

        // Randomized operand updates.
        for (int r = 0; r < 5; r++) begin
            for (int w = 0; w < 6; w++) begin
                write_op(1'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
                         int'($urandom_range(0, N - 1)), 8'($urandom));
            end
            do_run($sformatf("rand%0d", r), 1'b0, -1, 1'b0);
        end

        // Reset in the middle of a run.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        #2 rst_n = 1'b0;
        #1;
        clear_model();
        check_val("midrst.a",     64'(a_out),      64'd0);
        check_val("midrst.b",     64'(b_out),      64'd0);
        check_val("midrst.busy",  64'(busy),       64'd0);
        check_val("midrst.valid", 64'(feed_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < T + 2; c++) begin
            tick();
            check_val("midrst.no_done", 64'(done), 64'd0);
        end
        do_run("post_reset", 1'b0, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
